light_length_scheduler: RTL and testbench
=========================================

# light_length_scheduler

Adaptive phase-length scheduler that sits directly upstream of the traffic light controller. It observes the controller's `light`, `carCount` and `walkCount` outputs, measures per-cycle demand, and drives the controller's `gLength`, `yLength` and `rLength` inputs. Green time grows under heavy traffic and shrinks under light traffic, within bounds. Red time is extended after a cycle in which pedestrians walked.

## Interface
- `G_MIN`, 16: lower clamp for `gLength`
- `G_MAX`, 512: upper clamp for `gLength` (≤ 2047)
- `G_DEFAULT`, 64: `gLength` after reset
- `G_STEP`, 16: adjustment per cycle
- `Y_LEN`, 8: constant `yLength`
- `R_BASE`, 48: `rLength` when no walk occurred
- `R_WALK_EXT`, 32: added to `R_BASE` after a walk cycle
- `HI_THRESH`, 60: `cycleCars` ≥ this → lengthen green
- `LO_THRESH`, 20: `cycleCars` ≤ this → shorten green
- `clock` in 1: single clock, posedge
- `reset` in 1: asynchronous, active-high
- `light` in 2: controller light; 2'b10 green, 2'b01 yellow, 2'b00 red, 2'b11 illegal
- `carCount` in 9: controller car counter, free-running, wraps mod 512
- `walkCount` in 9: controller walk counter, wraps mod 512
- `gLength` out 11: green length for the next cycle
- `yLength` out 11: yellow length
- `rLength` out 11: red length
- `cycleCars` out 9: cars passed in the last completed green+yellow span
- `update` out 1: one-cycle pulse when `gLength` is recomputed
- `err` out 1: sticky flag; `light` == 2'b11 was seen

## Operation
- **Registers**
  - `lightPrev` (reset 2'b00)
  - `startCars`, `startWalk` snapshots
  - `armed` flag (reset 0)
  - FSM
- **FSM states**
  - **WAIT**: reset state. On green entry, go to GREEN.
  - **GREEN**: light 10 or 01. On red entry, go to CALC.
  - **CALC**: single cycle. Go to RED.
  - **RED**: on green entry, go to GREEN.
- **Green entry** (light==10 && lightPrev!=10):
  - `startCars`<=`carCount`; `armed`<=1.
  - If coming from RED: `rLength` <= `R_BASE`+`R_WALK_EXT` if (`walkCount`−`startWalk`) mod 512 ≠ 0, else `R_BASE`.
- **Red entry** (light==00 && lightPrev!=00):
  - If `armed`: `cycleCars` <= (`carCount`−`startCars`) mod 512, computed as a 9-bit subtraction so wrap is handled.
  - `startWalk` <= `walkCount`.
  - A red entry with `armed`==0 (e.g. the first red after reset) updates only `startWalk`; FSM stays WAIT.
- **CALC**, using a 12-bit intermediate:
  - `cycleCars` ≥ `HI_THRESH`: `gLength` = min(`gLength`+`G_STEP`, `G_MAX`).
  - Else `cycleCars` ≤ `LO_THRESH`: `gLength` = max(`gLength`−`G_STEP`, `G_MIN`).
  - Else `gLength` unchanged.
  - `update`=1 for this cycle regardless of whether the value changed.
- `yLength` is always `Y_LEN`.
- **Illegal light 2'b11**
  - `err`<=1 (cleared only by reset).
  - FSM, snapshots and outputs hold.
  - `lightPrev` is not updated, so the next legal value is compared against the last legal one.
- **Reset mid-operation**: all state returns to reset values immediately. The next cycle restarts from WAIT with no measurement in flight.

## Timing
- Outputs are registered; there are no combinational paths from input to output.
- Reset values:
  - `gLength`=`G_DEFAULT`, `yLength`=`Y_LEN`, `rLength`=`R_BASE`
  - `cycleCars`=0, `update`=0, `err`=0
- Red first sampled at edge N:
  - `cycleCars` is valid after edge N.
  - `gLength` changes and `update`=1 after edge N+1.
  - `update` returns to 0 after edge N+2.
- Green first sampled at edge M: `rLength` is valid after edge M.
- `gLength` changes only during red, one cycle after red entry. It is therefore stable throughout green and yellow.
- Yellow→green (illegal sequence for the controller) counts as green entry. `startCars` is re-snapshotted, and `rLength` is not changed because the FSM is not in RED.
- Red/green transitions one cycle apart are both honoured. CALC always takes exactly one cycle and is not skipped.

## Test plan
- **Reset defaults**: assert `reset` asynchronously mid-cycle → outputs are 64/8/48/0/0/0 before the next edge.
- **Heavy traffic**: green with `carCount` 0→70, then red → `cycleCars`=70 and `gLength`=80 one cycle later, with a one-cycle `update` pulse.
- **Light traffic and clamps**:
  - Repeated cycles with 5 cars → `gLength` steps 64→48→32→16→16.
  - Repeated cycles with 100 cars starting at 512 → `gLength` stays at 512.
- **Counter wrap**: `startCars`=500, `carCount`=50 at red entry → `cycleCars`=62 and `gLength` increases by 16.
- **Walk extension**:
  - `walkCount` 5→9 during red, then green → `rLength`=80.
  - Next cycle with no walks → `rLength`=48.
- **Illegal light and reset mid-red**:
  - `light`=11 for 3 cycles → `err`=1 sticky, no `update`, `gLength` unchanged.
  - Reset during red, then red→green→red sequence → first red ignored, first `update` only after a full green span.

Source files
------------

// File: rtl/light_length_scheduler_if.sv
// Bus between the adaptive phase-length scheduler and the traffic light controller.
// The controller side (master) drives light/counters; the scheduler (slave) drives lengths.
interface light_length_scheduler_if;
   logic [1:0]  light;
   logic [8:0]  carCount;
   logic [8:0]  walkCount;
   logic [10:0] gLength;
   logic [10:0] yLength;
   logic [10:0] rLength;
   logic [8:0]  cycleCars;
   logic        update;
   logic        err;

   modport master (
      output light, carCount, walkCount,
      input  gLength, yLength, rLength, cycleCars, update, err
   );

   modport slave (
      input  light, carCount, walkCount,
      output gLength, yLength, rLength, cycleCars, update, err
   );
endinterface

// File: rtl/light_length_scheduler.sv
// Adaptive phase-length scheduler: measures cars per green+yellow span and walks per
// red span from the controller's free-running counters, then retunes green/red lengths.
module light_length_scheduler #(
   parameter int unsigned G_MIN      = 16,
   parameter int unsigned G_MAX      = 512,
   parameter int unsigned G_DEFAULT  = 64,
   parameter int unsigned G_STEP     = 16,
   parameter int unsigned Y_LEN      = 8,
   parameter int unsigned R_BASE     = 48,
   parameter int unsigned R_WALK_EXT = 32,
   parameter int unsigned HI_THRESH  = 60,
   parameter int unsigned LO_THRESH  = 20
) (
   input logic clock,
   input logic reset,
   light_length_scheduler_if.slave bus
);

   localparam logic [1:0]  LIGHT_GREEN = 2'b10;
   localparam logic [1:0]  LIGHT_RED   = 2'b00;
   localparam logic [1:0]  LIGHT_BAD   = 2'b11;

   localparam logic [11:0] G_MIN_W   = 12'(G_MIN);
   localparam logic [11:0] G_MAX_W   = 12'(G_MAX);
   localparam logic [11:0] G_STEP_W  = 12'(G_STEP);
   localparam logic [11:0] HI_W      = 12'(HI_THRESH);
   localparam logic [11:0] LO_W      = 12'(LO_THRESH);
   localparam logic [10:0] G_DEF_W   = 11'(G_DEFAULT);
   localparam logic [10:0] Y_LEN_W   = 11'(Y_LEN);
   localparam logic [10:0] R_BASE_W  = 11'(R_BASE);
   localparam logic [10:0] R_EXT_W   = 11'(R_BASE + R_WALK_EXT);

   typedef enum logic [1:0] {
      S_WAIT,
      S_GREEN,
      S_CALC,
      S_RED
   } state_t;

   state_t      state;
   state_t      state_next;

   logic [1:0]  light_prev;
   logic [8:0]  start_cars;
   logic [8:0]  start_walk;
   logic        armed;
   logic [10:0] g_len;
   logic [10:0] r_len;
   logic [8:0]  cycle_cars;
   logic        upd;
   logic        err_flag;

   logic        legal;
   logic        green_entry;
   logic        red_entry;
   logic        do_calc;
   logic        load_r;
   logic [8:0]  car_delta;
   logic [8:0]  walk_delta;
   logic [11:0] g_wide;
   logic [11:0] g_inc;
   logic [11:0] g_dec;
   logic [11:0] cars_wide;
   logic [10:0] g_next;

   // Edge detection against the last legal light value, and wrap-safe counter deltas.
   always_comb begin
      legal       = (bus.light != LIGHT_BAD);
      green_entry = legal && (bus.light == LIGHT_GREEN) && (light_prev != LIGHT_GREEN);
      red_entry   = legal && (bus.light == LIGHT_RED)   && (light_prev != LIGHT_RED);
      car_delta   = bus.carCount - start_cars;
      walk_delta  = bus.walkCount - start_walk;
   end

   // FSM state register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= S_WAIT;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and control strobes. CALC is left after one cycle even if the light
   // is illegal in that cycle, so a closed measurement is never lost or repeated; a
   // green entry seen during CALC belongs to the same red span as RED does.
   always_comb begin
      state_next = state;
      do_calc    = 1'b0;
      load_r     = 1'b0;
      unique case (state)
         S_WAIT: begin
            if (green_entry) state_next = S_GREEN;
         end
         S_GREEN: begin
            if (red_entry) state_next = S_CALC;
         end
         S_CALC: begin
            do_calc    = 1'b1;
            load_r     = 1'b1;
            state_next = green_entry ? S_GREEN : S_RED;
         end
         S_RED: begin
            load_r = 1'b1;
            if (green_entry) state_next = S_GREEN;
         end
         default: state_next = S_WAIT;
      endcase
   end

   // Clamped green-length step, evaluated 12 bits wide so neither bound can wrap.
   always_comb begin
      g_wide    = {1'b0, g_len};
      g_inc     = g_wide + G_STEP_W;
      g_dec     = g_wide - G_STEP_W;
      cars_wide = {3'b000, cycle_cars};
      g_next    = g_len;
      if (cars_wide >= HI_W) begin
         g_next = (g_inc > G_MAX_W) ? G_MAX_W[10:0] : g_inc[10:0];
      end else if (cars_wide <= LO_W) begin
         g_next = (g_wide < (G_MIN_W + G_STEP_W)) ? G_MIN_W[10:0] : g_dec[10:0];
      end
   end

   // Snapshots, measurements and registered outputs; an illegal light only sets err.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         light_prev <= LIGHT_RED;
         start_cars <= '0;
         start_walk <= '0;
         armed      <= 1'b0;
         g_len      <= G_DEF_W;
         r_len      <= R_BASE_W;
         cycle_cars <= '0;
         upd        <= 1'b0;
         err_flag   <= 1'b0;
      end else begin
         upd <= do_calc;
         if (do_calc) begin
            g_len <= g_next;
         end
         if (!legal) begin
            err_flag <= 1'b1;
         end else begin
            light_prev <= bus.light;
         end
         if (green_entry) begin
            start_cars <= bus.carCount;
            armed      <= 1'b1;
            if (load_r) begin
               r_len <= (walk_delta != '0) ? R_EXT_W : R_BASE_W;
            end
         end
         if (red_entry) begin
            if (armed) begin
               cycle_cars <= car_delta;
            end
            start_walk <= bus.walkCount;
         end
      end
   end

   assign bus.gLength   = g_len;
   assign bus.yLength   = Y_LEN_W;
   assign bus.rLength   = r_len;
   assign bus.cycleCars = cycle_cars;
   assign bus.update    = upd;
   assign bus.err       = err_flag;

endmodule

// File: tb/tb_light_length_scheduler.sv
// Bench for light_length_scheduler: directed scenarios plus randomized light cycles,
// every cycle compared against an event-level reference model of the scheduling rules.
module tb_light_length_scheduler;

   localparam logic [1:0] GRN = 2'b10;
   localparam logic [1:0] YEL = 2'b01;
   localparam logic [1:0] RED = 2'b00;
   localparam logic [1:0] BAD = 2'b11;

   logic clock;
   logic reset;
   int   n_tests;
   int   n_fail;
   int   cars;
   int   walks;

   // reference model state (plain integers)
   int   m_g, m_r, m_cc, m_upd, m_err;
   int   m_prev, m_start_cars, m_start_walk, m_armed;
   int   m_green_span, m_red_span, m_calc_due;

   light_length_scheduler_if bus ();

   light_length_scheduler #(
      .G_MIN      (16),
      .G_MAX      (512),
      .G_DEFAULT  (64),
      .G_STEP     (16),
      .Y_LEN      (8),
      .R_BASE     (48),
      .R_WALK_EXT (32),
      .HI_THRESH  (60),
      .LO_THRESH  (20)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_g = 64; m_r = 48; m_cc = 0; m_upd = 0; m_err = 0;
      m_prev = 0; m_start_cars = 0; m_start_walk = 0; m_armed = 0;
      m_green_span = 0; m_red_span = 0; m_calc_due = 0;
   endtask

   // One clock edge of the scheduling rules, seen as events on the light sequence.
   task automatic model_edge(input int l, input int c, input int w);
      m_upd = m_calc_due;
      if (m_calc_due != 0) begin
         if (m_cc >= 60)      m_g = (m_g + 16 > 512) ? 512 : m_g + 16;
         else if (m_cc <= 20) m_g = (m_g - 16 < 16) ? 16 : m_g - 16;
         m_calc_due = 0;
      end
      if (l == 3) begin
         m_err = 1;
         return;
      end
      if (l == 2 && m_prev != 2) begin
         if (m_red_span != 0) m_r = (((w - m_start_walk + 512) % 512) != 0) ? 80 : 48;
         m_start_cars = c;
         m_armed      = 1;
         m_green_span = 1;
         m_red_span   = 0;
      end else if (l == 0 && m_prev != 0) begin
         if (m_armed != 0) m_cc = (c - m_start_cars + 512) % 512;
         m_start_walk = w;
         if (m_green_span != 0) begin
            m_calc_due   = 1;
            m_green_span = 0;
            m_red_span   = 1;
         end
      end
      m_prev = l;
   endtask

   task automatic compare_all();
      check("gLength",   32'(bus.gLength),   32'(m_g));
      check("yLength",   32'(bus.yLength),   32'd8);
      check("rLength",   32'(bus.rLength),   32'(m_r));
      check("cycleCars", 32'(bus.cycleCars), 32'(m_cc));
      check("update",    32'(bus.update),    32'(m_upd));
      check("err",       32'(bus.err),       32'(m_err));
   endtask

   task automatic step(input logic [1:0] l);
      bus.light     = l;
      bus.carCount  = 9'(cars);
      bus.walkCount = 9'(walks);
      @(posedge clock);
      model_edge(int'(l), cars, walks);
      #1;
      compare_all();
   endtask

   task automatic phase(input logic [1:0] l, input int n, input int add_c, input int add_w);
      for (int i = 0; i < n; i++) begin
         if (i == 1) begin
            cars  = (cars + add_c) % 512;
            walks = (walks + add_w) % 512;
         end
         step(l);
      end
   endtask

   task automatic full_cycle(input int n_cars, input int n_walk);
      phase(GRN, 3, n_cars, 0);
      phase(YEL, 2, 0, 0);
      phase(RED, 3, 0, n_walk);
   endtask

   // Asserted mid-cycle; outputs must be at reset values before the next edge.
   task automatic do_reset();
      #3;
      reset = 1'b1;
      model_reset();
      #1;
      compare_all();
      @(posedge clock);
      #1;
      reset = 1'b0;
      compare_all();
   endtask

   initial begin
      int g_hold;
      logic [31:0] g_exp [4];
      g_exp[0] = 48; g_exp[1] = 32; g_exp[2] = 16; g_exp[3] = 16;
      n_tests = 0;
      n_fail  = 0;
      cars    = 0;
      walks   = 0;
      reset   = 1'b1;
      bus.light     = RED;
      bus.carCount  = '0;
      bus.walkCount = '0;
      model_reset();
      @(posedge clock);
      #1;
      reset = 1'b0;

      // reset defaults, asynchronous assertion
      do_reset();
      check("rst_g",   32'(bus.gLength),   32'd64);
      check("rst_r",   32'(bus.rLength),   32'd48);
      check("rst_upd", 32'(bus.update),    32'd0);
      check("rst_err", 32'(bus.err),       32'd0);
      check("rst_cc",  32'(bus.cycleCars), 32'd0);

      // heavy traffic: 70 cars
      phase(GRN, 3, 70, 0);
      phase(YEL, 2, 0, 0);
      step(RED);
      check("heavy_cc",   32'(bus.cycleCars), 32'd70);
      check("heavy_upd0", 32'(bus.update),    32'd0);
      check("heavy_g0",   32'(bus.gLength),   32'd64);
      step(RED);
      check("heavy_g",    32'(bus.gLength),   32'd80);
      check("heavy_upd1", 32'(bus.update),    32'd1);
      step(RED);
      check("heavy_upd2", 32'(bus.update),    32'd0);

      // light traffic down to the lower clamp
      do_reset();
      for (int k = 0; k < 4; k++) begin
         full_cycle(5, 0);
         check("light_g", 32'(bus.gLength), g_exp[k]);
      end

      // car counter wrap: 500 -> 50
      cars = 500;
      full_cycle(62, 0);
      check("wrap_cc", 32'(bus.cycleCars), 32'd62);
      check("wrap_g",  32'(bus.gLength),   32'd32);

      // walk extension then return to base
      walks = 5;
      full_cycle(30, 4);
      step(GRN);
      check("walk_r_ext", 32'(bus.rLength), 32'd80);
      phase(GRN, 2, 30, 0);
      phase(YEL, 2, 0, 0);
      phase(RED, 3, 0, 0);
      step(GRN);
      check("walk_r_base", 32'(bus.rLength), 32'd48);

      // illegal light during green
      g_hold = m_g;
      for (int k = 0; k < 3; k++) begin
         step(BAD);
         check("bad_err", 32'(bus.err),     32'd1);
         check("bad_upd", 32'(bus.update),  32'd0);
         check("bad_g",   32'(bus.gLength), 32'(g_hold));
      end
      phase(GRN, 2, 10, 0);
      phase(YEL, 2, 0, 0);
      phase(RED, 3, 0, 0);
      check("bad_sticky", 32'(bus.err), 32'd1);

      // upper clamp
      for (int k = 0; k < 32; k++) full_cycle(100, 0);
      check("clamp_hi_a", 32'(bus.gLength), 32'd512);
      for (int k = 0; k < 2; k++) full_cycle(100, 0);
      check("clamp_hi_b", 32'(bus.gLength), 32'd512);

      // reset in red: ongoing red ignored, first update after a full green span
      phase(GRN, 2, 0, 0);
      phase(YEL, 1, 0, 0);
      phase(RED, 2, 0, 0);
      do_reset();
      phase(RED, 3, 0, 0);
      check("rr_upd_idle", 32'(bus.update), 32'd0);
      phase(GRN, 3, 70, 0);
      phase(YEL, 2, 0, 0);
      step(RED);
      check("rr_upd0", 32'(bus.update), 32'd0);
      step(RED);
      check("rr_upd1", 32'(bus.update),  32'd1);
      check("rr_g",    32'(bus.gLength), 32'd80);

      // randomized light cycles
      for (int k = 0; k < 60; k++) begin
         phase(GRN, int'($urandom_range(2, 5)), int'($urandom_range(0, 150)), 0);
         if ($urandom_range(0, 5) == 0) begin
            repeat (int'($urandom_range(1, 2))) step(BAD);
         end
         if ($urandom_range(0, 4) == 0) begin
            phase(YEL, 1, 0, 0);
            phase(GRN, 2, int'($urandom_range(0, 150)), 0);
         end
         phase(YEL, int'($urandom_range(1, 3)), 0, 0);
         phase(RED, int'($urandom_range(2, 5)), 0,
               ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 5)) : 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
